lsu_mem_master: RTL and testbench
=================================

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the width of the word address driven to data memory (64 words).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req_valid  input  1  SHALL be the core's load/store request strobe.
REQ-005 req_store  input  1  SHALL select store (1) or load (0).
REQ-006 req_f3  input  3  SHALL carry the RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 req_addr  input  32  SHALL carry the byte address.
REQ-008 req_wdata  input  32  SHALL carry store data, right-aligned.
REQ-009 req_ready  output  1  SHALL be high only in IDLE.
REQ-010 resp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-011 resp_err  output  1  SHALL flag a misaligned access or an illegal f3, valid with resp_valid.
REQ-012 resp_rdata  output  32  SHALL carry extended load data, valid with resp_valid.
REQ-013 mem_read, mem_write  output  1 each  SHALL be memory access strobes, never high together.
REQ-014 mem_addr  output  ADDR_W  SHALL equal req_addr[ADDR_W+1:2], latched at acceptance.
REQ-015 mem_wdata  output  32  SHALL carry the full word to write.
REQ-016 mem_rdata  input  32  SHALL carry the read word, sampled on mem_ack.
REQ-017 mem_ack  input  1  SHALL be the memory completion pulse for the current strobe.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
REQ-019 In IDLE, req_valid=1 SHALL latch the request (the handshake is req_valid & req_ready); req_addr bits above ADDR_W+1 are ignored.
REQ-020 An error request SHALL go to RESP with resp_err=1, resp_rdata=0, and no memory strobe. Error cases: f3 011/110/111; H/HU with addr[0]=1; W with addr[1:0]!=0; for stores, f3 100/101 are also errors.
REQ-021 Loads and SW SHALL go to ACCESS; SB/SH SHALL go to RMW_RD.
REQ-022 ACCESS SHALL hold mem_read (load) or mem_write with mem_wdata=req_wdata (SW) until mem_ack, then go to RESP.
REQ-023 RMW_RD SHALL hold mem_read until mem_ack, capture mem_rdata, merge store data into the selected lane, then go to RMW_WR.
REQ-024 SB lane SHALL be addr[1:0] (data bits 8*lane+7:8*lane); SH lane SHALL be addr[1] (16*addr[1]+15:16*addr[1]); other bits SHALL be preserved.
REQ-025 RMW_WR SHALL hold mem_write with the merged word until mem_ack, then go to RESP.
REQ-026 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; there is no response back-pressure.
REQ-027 Load extraction: LB sign-extends the selected byte; LBU zero-extends it; LH sign-extends the selected half; LHU zero-extends it; LW passes the word. Stores return resp_rdata=0.
REQ-028 mem_ack SHALL be ignored in IDLE and RESP.
REQ-029 Latency with mem_ack on the first strobe cycle: load/SW resp_valid 2 cycles after acceptance; SB/SH 3 cycles; error 1 cycle.
REQ-030 req_valid outside IDLE SHALL be ignored; the core holds it until accepted.

Reset
REQ-031 rst=1 at any clock edge SHALL force IDLE and clear all outputs to 0 (req_ready=1) on that edge, including mid-access; the aborted request produces no response.
REQ-032 An access aborted by reset SHALL NOT be retried; a pending mem_ack after reset SHALL be ignored.

Verification
REQ-033 Memory word 5 = 0x80FF1234; LB at addr 0x16 -> resp_rdata=0xFFFFFFFF; LBU at 0x17 -> 0x00000080; LH at 0x16 -> 0xFFFF80FF.
REQ-034 Memory word 2 = 0xAABBCCDD; SB 0x11 at addr 0x09 -> read then write of 0xAABB11DD to mem_addr 2; resp_valid 3 cycles after acceptance.
REQ-035 LW at 0x06 -> resp_err=1 one cycle after acceptance, mem_read/mem_write never asserted.
REQ-036 LW with mem_ack delayed 4 cycles -> mem_read held 4 cycles, single resp_valid, req_ready low throughout.
REQ-037 rst during RMW_WR -> mem_write low on the next edge, no resp_valid, req_ready=1; a stray mem_ack afterwards has no effect.
REQ-038 SW 0x12345678 at addr 0xFC (word 63) -> mem_addr=63, mem_wdata=0x12345678, no read.

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: turns core load/store requests into word-wide
// memory accesses, using read-modify-write for byte and halfword stores.
module lsu_mem_master #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_store,
    input  logic [2:0]        req_f3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic              store_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              req_err;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic              unused_addr;

    // Address bits above the memory window are deliberately dropped.
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    always_comb begin
        req_err = 1'b1;
        case (req_f3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = (req_addr[1:0] != 2'b00);
            3'b100:  req_err = req_store;
            3'b101:  req_err = req_store | req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_data = mem_rdata;
        case (f3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Only SB (f3 000) and SH (f3 001) reach the merge, so f3_q[0] picks the width.
    always_comb begin
        merged = mem_rdata;
        if (!f3_q[0]) begin
            case (lane_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request handshake: a request transfers on a cycle where req_valid and
    // req_ready are both high; req_ready is high only in IDLE. Responses are a
    // single resp_valid cycle with no back-pressure.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                          state_nxt = RESP;
                    else if (req_store && req_f3 != 3'b010) state_nxt = RMW_RD;
                    else                                  state_nxt = ACCESS;
                end
            end
            ACCESS:  if (mem_ack) state_nxt = RESP;
            RMW_RD:  if (mem_ack) state_nxt = RMW_WR;
            RMW_WR:  if (mem_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q      <= 1'b0;
            f3_q         <= 3'd0;
            lane_q       <= 2'd0;
            wdata_q      <= 16'd0;
            addr_q       <= '0;
            mem_wdata_q  <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q      <= req_store;
                        f3_q         <= req_f3;
                        lane_q       <= req_addr[1:0];
                        wdata_q      <= req_wdata[15:0];
                        addr_q       <= req_addr[ADDR_W+1:2];
                        mem_wdata_q  <= (req_store && req_f3 == 3'b010 && !req_err) ? req_wdata : 32'd0;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= req_err;
                    end
                end
                ACCESS: begin
                    if (mem_ack && !store_q) resp_rdata_q <= load_data;
                end
                RMW_RD: begin
                    if (mem_ack) mem_wdata_q <= merged;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_read   = ((state == ACCESS) && !store_q) || (state == RMW_RD);
    assign mem_write  = ((state == ACCESS) && store_q) || (state == RMW_WR);
    assign mem_addr   = addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: word-addressed memory model with
// programmable ack delay, hand-computed load/store results and latencies.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_store;
    logic [2:0]  req_f3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_store(req_store), .req_f3(req_f3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_state(dbg_state)
    );

    // Memory model: ack arrives on the hold-th cycle of a strobe (0 = never).
    logic [31:0] mem [0:63];
    int          wait_cnt = 0;
    int          rd_hold = 1, wr_hold = 1;
    int          rd_cyc = 0, wr_cyc = 0, both_cyc = 0, resp_cnt = 0;
    logic        stray_ack = 1'b0;
    logic        pre_en = 1'b0;
    logic [5:0]  pre_addr = 6'd0;
    logic [31:0] pre_data = 32'd0;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = stray_ack
                     | (mem_read  && rd_hold > 0 && wait_cnt == rd_hold - 1)
                     | (mem_write && wr_hold > 0 && wait_cnt == wr_hold - 1);

    always @(posedge clk) begin
        if ((mem_read || mem_write) && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                                     wait_cnt <= 0;
        if (mem_write && mem_ack) mem[mem_addr] <= mem_wdata;
        if (pre_en) mem[pre_addr] <= pre_data;
        if (mem_read) rd_cyc <= rd_cyc + 1;
        if (mem_write) wr_cyc <= wr_cyc + 1;
        if (mem_read && mem_write) both_cyc <= both_cyc + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    int          t_lat, t_rd, t_wr, t_ready_hi;
    logic        t_err, t_resp_after;
    logic [31:0] t_rdata;

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
        int rd0, wr0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_f3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rd0 = rd_cyc; wr0 = wr_cyc;
        t_lat = -1; t_ready_hi = 0; t_err = 1'bx; t_rdata = 'x;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (req_ready) t_ready_hi++;
            if (resp_valid) begin
                t_lat = i; t_err = resp_err; t_rdata = resp_rdata;
                break;
            end
        end
        t_rd = rd_cyc - rd0;
        t_wr = wr_cyc - wr0;
        @(negedge clk);
        t_resp_after = resp_valid;
    endtask

    task automatic chk_txn(input string tag, input int lat, input logic err,
                           input logic [31:0] rdata, input int rd, input int wr);
        chk({tag, "_lat"}, t_lat, lat);
        chk({tag, "_err"}, {31'd0, t_err}, {31'd0, err});
        chk({tag, "_rdata"}, t_rdata, rdata);
        chk({tag, "_rd_cycles"}, t_rd, rd);
        chk({tag, "_wr_cycles"}, t_wr, wr);
        chk({tag, "_ready_busy"}, t_ready_hi, 0);
        chk({tag, "_single_resp"}, {31'd0, t_resp_after}, 32'd0);
    endtask

    int rc0, rd0, wr0;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_f3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        preload(6'd5, 32'h80FF1234);
        preload(6'd2, 32'hAABBCCDD);
        preload(6'd7, 32'hCAFEF00D);
        preload(6'd3, 32'h33333333);
        preload(6'd63, 32'h00000000);

        // Loads from word 5 = 0x80FF1234
        do_req(1'b0, 3'b000, 32'h16, 32'd0);  chk_txn("lb_16",   2, 1'b0, 32'hFFFFFFFF, 1, 0);
        do_req(1'b0, 3'b100, 32'h17, 32'd0);  chk_txn("lbu_17",  2, 1'b0, 32'h00000080, 1, 0);
        do_req(1'b0, 3'b001, 32'h16, 32'd0);  chk_txn("lh_16",   2, 1'b0, 32'hFFFF80FF, 1, 0);
        do_req(1'b0, 3'b101, 32'h14, 32'd0);  chk_txn("lhu_14",  2, 1'b0, 32'h00001234, 1, 0);
        do_req(1'b0, 3'b000, 32'h14, 32'd0);  chk_txn("lb_14",   2, 1'b0, 32'h00000034, 1, 0);
        do_req(1'b0, 3'b010, 32'h114, 32'd0); chk_txn("lw_114",  2, 1'b0, 32'h80FF1234, 1, 0);

        // Error requests: no strobes, rdata forced to zero
        do_req(1'b0, 3'b010, 32'h06, 32'd0);  chk_txn("lw_mis",  1, 1'b1, 32'd0, 0, 0);
        do_req(1'b0, 3'b001, 32'h15, 32'd0);  chk_txn("lh_mis",  1, 1'b1, 32'd0, 0, 0);
        do_req(1'b0, 3'b011, 32'h00, 32'd0);  chk_txn("f3_011",  1, 1'b1, 32'd0, 0, 0);
        do_req(1'b1, 3'b100, 32'h0C, 32'h55); chk_txn("st_bu",   1, 1'b1, 32'd0, 0, 0);
        do_req(1'b1, 3'b010, 32'h0E, 32'h99); chk_txn("sw_mis",  1, 1'b1, 32'd0, 0, 0);
        chk("sw_mis_mem3", mem[3], 32'h33333333);

        // Sub-word stores into word 2 = 0xAABBCCDD
        do_req(1'b1, 3'b000, 32'h09, 32'h11);     chk_txn("sb_09", 3, 1'b0, 32'd0, 1, 1);
        chk("sb_09_mem2", mem[2], 32'hAABB11DD);
        do_req(1'b1, 3'b001, 32'h0A, 32'h0000BEEF); chk_txn("sh_0a", 3, 1'b0, 32'd0, 1, 1);
        chk("sh_0a_mem2", mem[2], 32'hBEEF11DD);

        // Full-word store to the top word
        do_req(1'b1, 3'b010, 32'hFC, 32'h12345678); chk_txn("sw_fc", 2, 1'b0, 32'd0, 0, 1);
        chk("sw_fc_mem63", mem[63], 32'h12345678);

        // Slow memory: ack on the fourth read cycle
        rd_hold = 4;
        do_req(1'b0, 3'b010, 32'h1C, 32'd0);  chk_txn("lw_slow", 5, 1'b0, 32'hCAFEF00D, 4, 0);
        rd_hold = 1;

        // Reset during RMW_WR, then a stray ack
        wr_hold = 0;
        rc0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_f3 = 3'b000; req_addr = 32'h08; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_rmw_rd", {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        chk("abort_rmw_wr", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_mem_addr", {26'd0, mem_addr}, 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0; wr_hold = 1; stray_ack = 1'b1;
        rd0 = rd_cyc; wr0 = wr_cyc;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_resp_cnt", resp_cnt - rc0, 0);
        chk("stray_rd", rd_cyc - rd0, 0);
        chk("stray_wr", wr_cyc - wr0, 0);
        chk("stray_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_mem2", mem[2], 32'hBEEF11DD);

        // Normal operation resumes
        do_req(1'b0, 3'b010, 32'h14, 32'd0);  chk_txn("lw_after", 2, 1'b0, 32'h80FF1234, 1, 0);
        chk("never_both_strobes", both_cyc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
